// File: rtl/cpu_pkg.sv
// Shared constants for the pipelined CPU: reset/bubble values, opcodes and the
// jump-target helper used by the fetch stage.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Pseudo-direct j addressing: upper nibble of PC+4, 26-bit word index.
  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with hold and next-PC selection
// (hold > jump > branch > sequential).
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hold_i,
  input  logic        jump_i,
  input  logic        branch_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;

  always_comb begin
    pc_plus4_o = pc_q + PC_INC;
    pc_next    = pc_q;
    if (!hold_i) begin
      if (jump_i)
        pc_next = jump_target_i;
      else if (branch_i)
        pc_next = branch_target_i;
      else
        pc_next = pc_plus4_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_next;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch, and fetch/flush
// event counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_instr_o,
  output logic [5:0]  ifid_op_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic [31:0] fetch_cnt_o,
  output logic [15:0] flush_cnt_o
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        hold;
  logic        jump_q;
  logic        branch_q;
  logic        redirect;

  // A redirect sitting on a bubble is stale; only a real ID instruction may steer fetch.
  assign hold     = ~start_i | stall_i;
  assign jump_q   = jump_i & ifid_valid_o;
  assign branch_q = branch_taken_i & ifid_valid_o;
  assign redirect = jump_q | branch_q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .hold_i          (hold),
    .jump_i          (jump_q),
    .branch_i        (branch_q),
    .jump_target_i   (jump_target(ifid_pc4_o, ifid_instr_o)),
    .branch_target_i (branch_target_i),
    .pc_o            (pc),
    .pc_plus4_o      (pc_plus4)
  );

  assign imem_addr_o = pc;
  assign ifid_op_o   = ifid_instr_o[31:26];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ifid_instr_o <= NOP_WORD;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
      fetch_cnt_o  <= '0;
      flush_cnt_o  <= '0;
    end else if (stall_i) begin
      ifid_instr_o <= ifid_instr_o;
    end else if (!start_i) begin
      ifid_instr_o <= NOP_WORD;
      ifid_valid_o <= 1'b0;
    end else if (redirect) begin
      // The wrong-path instruction becomes a bubble; pc4 is left as it was.
      ifid_instr_o <= NOP_WORD;
      ifid_valid_o <= 1'b0;
      if (flush_cnt_o != 16'hFFFF)
        flush_cnt_o <= flush_cnt_o + 16'd1;
    end else begin
      ifid_instr_o <= imem_data_i;
      ifid_pc4_o   <= pc_plus4;
      ifid_valid_o <= 1'b1;
      fetch_cnt_o  <= fetch_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a behavioural model queues the expected
// state for every cycle, which is popped and compared after the clock edge.
module tb_if_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0020;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        jump_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] ifid_instr_o;
  logic [5:0]  ifid_op_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic [31:0] fetch_cnt_o;
  logic [15:0] flush_cnt_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fetch;
    logic [15:0] flush;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_fetch;
  logic [15:0] m_flush;

  if_stage #(
    .RESET_PC (TB_RESET_PC),
    .NOP_WORD (TB_NOP)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .ifid_instr_o    (ifid_instr_o),
    .ifid_op_o       (ifid_op_o),
    .ifid_pc4_o      (ifid_pc4_o),
    .ifid_valid_o    (ifid_valid_o),
    .fetch_cnt_o     (fetch_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Address-derived instruction memory; address 0xC holds a j to word 0x40.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_000C)
      return 32'h0800_0040;
    return addr ^ 32'h1234_5678;
  endfunction

  assign imem_data_i = mem_word(imem_addr_o);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    m_pc    = TB_RESET_PC;
    m_instr = TB_NOP;
    m_pc4   = '0;
    m_valid = 1'b0;
    m_fetch = '0;
    m_flush = '0;
    sb_q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pc"},    imem_addr_o, TB_RESET_PC);
    checkOutput({tag, "_instr"}, ifid_instr_o, TB_NOP);
    checkOutput({tag, "_pc4"},   ifid_pc4_o, 32'h0);
    checkOutput({tag, "_valid"}, {31'b0, ifid_valid_o}, 32'h0);
    checkOutput({tag, "_fetch"}, fetch_cnt_o, 32'h0);
    checkOutput({tag, "_flush"}, {16'b0, flush_cnt_o}, 32'h0);
  endtask

  task automatic compareAll();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput("sb_empty", 32'h1, 32'h0);
      return;
    end
    e = sb_q.pop_front();
    checkOutput("pc",    imem_addr_o, e.pc);
    checkOutput("instr", ifid_instr_o, e.instr);
    checkOutput("op",    {26'b0, ifid_op_o}, {26'b0, e.instr[31:26]});
    checkOutput("pc4",   ifid_pc4_o, e.pc4);
    checkOutput("valid", {31'b0, ifid_valid_o}, {31'b0, e.valid});
    checkOutput("fetch", fetch_cnt_o, e.fetch);
    checkOutput("flush", {16'b0, flush_cnt_o}, {16'b0, e.flush});
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic start, input logic stall, input logic br,
                               input logic [31:0] tgt, input logic jmp);
    exp_t e;
    start_i         = start;
    stall_i         = stall;
    branch_taken_i  = br;
    branch_target_i = tgt;
    jump_i          = jmp;
    if (!stall) begin
      if (!start) begin
        m_instr = TB_NOP;
        m_valid = 1'b0;
      end else if ((jmp || br) && m_valid) begin
        m_pc    = jmp ? {m_pc4[31:28], m_instr[25:0], 2'b00} : tgt;
        m_instr = TB_NOP;
        m_valid = 1'b0;
        if (m_flush != 16'hFFFF)
          m_flush = m_flush + 16'd1;
      end else begin
        m_instr = mem_word(m_pc);
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc;
        m_valid = 1'b1;
        m_fetch = m_fetch + 32'd1;
      end
    end
    e.pc    = m_pc;
    e.instr = m_instr;
    e.pc4   = m_pc4;
    e.valid = m_valid;
    e.fetch = m_fetch;
    e.flush = m_flush;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    compareAll();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetModel();
    #12;
    checkResetValues("por");
    @(negedge clk_i);
    rst_i = 1'b1;

    // Sequential fetch from reset
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("seq_pc4_1", ifid_pc4_o, 32'd4);
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("seq_pc4_2", ifid_pc4_o, 32'd8);
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("seq_pc4_3", ifid_pc4_o, 32'd12);
    checkOutput("seq_fetch", fetch_cnt_o, 32'd3);
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("jmp_setup", ifid_instr_o, 32'h0800_0040);

    // Jump from ID
    applyStimulus(1, 0, 0, 32'h0, 1);
    checkOutput("jmp_pc", imem_addr_o, 32'h0000_0100);
    checkOutput("jmp_bubble", {31'b0, ifid_valid_o}, 32'h0);
    checkOutput("jmp_pc4_kept", ifid_pc4_o, 32'h0000_0010);
    checkOutput("jmp_flush", {16'b0, flush_cnt_o}, 32'd1);

    // Redirect on a bubble is ignored
    applyStimulus(1, 0, 1, 32'h0000_0500, 0);
    checkOutput("bubble_redir_pc", imem_addr_o, 32'h0000_0104);
    checkOutput("bubble_redir_flush", {16'b0, flush_cnt_o}, 32'd1);

    // Branch under stall is held, then taken once the stall drops
    applyStimulus(1, 1, 1, 32'h0000_0020, 0);
    checkOutput("stall_pc", imem_addr_o, 32'h0000_0104);
    checkOutput("stall_flush", {16'b0, flush_cnt_o}, 32'd1);
    applyStimulus(1, 0, 1, 32'h0000_0020, 0);
    checkOutput("br_pc", imem_addr_o, 32'h0000_0020);
    checkOutput("br_flush", {16'b0, flush_cnt_o}, 32'd2);

    // Jump and branch together: jump wins, one flush
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0300, 1);
    checkOutput("jb_pc", imem_addr_o, 32'h08D1_5960);
    checkOutput("jb_flush", {16'b0, flush_cnt_o}, 32'd3);

    // start low freezes PC and inserts a bubble
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("start_lo_pc", imem_addr_o, 32'h08D1_5960);
    applyStimulus(1, 0, 0, 32'h0, 0);

    // PC wrap at the top of the address space
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0);
    checkOutput("wrap_setup", imem_addr_o, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("wrap_pc", imem_addr_o, 32'h0);
    checkOutput("wrap_pc4", ifid_pc4_o, 32'h0);

    // Mixed random traffic
    for (int i = 0; i < 24; i++) begin
      applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), ($urandom() & 32'hFFFF_FFFC),
                    ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset between edges during a stall with a pending branch
    applyStimulus(1, 1, 1, 32'h0000_0040, 0);
    #2;
    rst_i = 1'b0;
    #1;
    checkResetValues("async_rst");
    resetModel();
    #1;
    rst_i = 1'b1;
    applyStimulus(1, 0, 0, 32'h0, 0);
    checkOutput("restart_pc4", ifid_pc4_o, 32'd4);
    checkOutput("restart_instr", ifid_instr_o, mem_word(TB_RESET_PC));
    checkOutput("restart_flush", {16'b0, flush_cnt_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded at reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000, instruction word inserted on flush or bubble.
REQ-003 SHALL have port clk_i, input, 1, single rising-edge clock for all state.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1; high enables PC advance, low freezes fetch.
REQ-006 SHALL have port stall_i, input, 1, load-use hazard hold from the ID stage.
REQ-007 SHALL have port branch_taken_i, input, 1, resolved taken beq in ID.
REQ-008 SHALL have port branch_target_i, input, 32, byte address of the taken-branch target.
REQ-009 SHALL have port jump_i, input, 1, decoded j in ID.
REQ-010 SHALL have port imem_addr_o, output, 32, instruction memory address, equal to the current PC.
REQ-011 SHALL have port imem_data_i, input, 32, instruction word returned combinationally for imem_addr_o.
REQ-012 SHALL have port ifid_instr_o, output, 32, registered IF/ID instruction.
REQ-013 SHALL have port ifid_op_o, output, 6, ifid_instr_o[31:26], the opcode field sent to the decoder.
REQ-014 SHALL have port ifid_pc4_o, output, 32, registered PC+4 of the ID instruction.
REQ-015 SHALL have port ifid_valid_o, output, 1; high means the ID instruction is real, low means a bubble.
REQ-016 SHALL have port fetch_cnt_o, output, 32, count of instructions accepted into IF/ID.
REQ-017 SHALL have port flush_cnt_o, output, 16, count of flush events.

Function
REQ-018 Next PC SHALL follow this priority: hold (start_i low or stall_i high) > jump > branch > PC+4.
REQ-019 Jump target SHALL be {ifid_pc4_o[31:28], ifid_instr_o[25:0], 2'b00}.
REQ-020 Branch target SHALL be branch_target_i, used as given.
REQ-021 PC+4 SHALL be a 32-bit sum that wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
REQ-022 Normal cycle (no hold, no redirect): IF/ID SHALL capture imem_data_i and PC+4, valid=1; fetch_cnt_o SHALL increment.
REQ-023 On jump_i or branch_taken_i with stall_i low: PC SHALL load the target.
REQ-024 In the same case, IF/ID SHALL load NOP_WORD, valid=0, pc4 unchanged.
REQ-025 In the same case, flush_cnt_o SHALL increment (saturating at 16'hFFFF) and fetch_cnt_o SHALL not increment.
REQ-026 jump_i and branch_taken_i together SHALL count as one flush, with the jump target winning.
REQ-027 stall_i high SHALL hold PC, IF/ID and both counters unchanged.
REQ-028 While stall_i is high, redirects SHALL be ignored; ID re-presents them after the stall.
REQ-029 start_i low (and stall_i low) SHALL hold PC and load IF/ID with NOP_WORD, valid=0.
REQ-030 Redirect inputs SHALL be qualified by ifid_valid_o; a redirect asserted on a bubble is ignored.
REQ-031 ifid_op_o SHALL be purely combinational from ifid_instr_o; opcode 6'b000000 with valid=0 is a bubble.
REQ-032 Latency SHALL be 1 cycle from PC to IF/ID, and a redirect SHALL take effect on the next edge.
REQ-033 fetch_cnt_o SHALL wrap modulo 2^32.

Reset
REQ-034 rst_i low SHALL immediately, without a clock, set PC=RESET_PC, ifid_instr_o=NOP_WORD, ifid_pc4_o=0, ifid_valid_o=0, and both counters to 0.
REQ-035 Reset mid-stall or mid-redirect SHALL discard the pending action.
REQ-036 The first fetch SHALL occur on the first rising edge with rst_i high and start_i high.

Structure
REQ-037 Shared package cpu_pkg SHALL hold RESET_PC, NOP_WORD, opcode constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J) and PC_INC=4.
REQ-038 Sub-module pc_reg SHALL hold the PC register with its hold and next-PC mux; IF/ID latch and counters SHALL remain in if_stage.

Verification
REQ-039 Reset, start_i=1, imem returns addr-based words -> ifid_pc4_o 4, 8, 12 on successive cycles; fetch_cnt_o=3 after 3 edges.
REQ-040 Jump at ID, ifid_pc4_o=32'h0000_0010, instr=32'h0800_0040 -> PC=32'h0000_0100; IF/ID bubble; flush_cnt_o=1.
REQ-041 branch_taken_i=1, branch_target_i=32'h0000_0020 together with stall_i=1 -> PC unchanged, no flush; after stall_i drops -> PC=32'h20.
REQ-042 jump_i and branch_taken_i together -> jump target loaded, flush_cnt_o increments by exactly 1.
REQ-043 PC=32'hFFFF_FFFC, normal cycle -> PC=32'h0, ifid_pc4_o=32'h0.
REQ-044 rst_i pulsed low between edges during a stall -> outputs reach reset values before the next edge; fetch restarts at RESET_PC.
